// File: rtl/serial_mag_comp_pkg.sv
// Shared definitions for the bit-serial magnitude comparator: FSM state
// encoding, default operand width and the bit-counter width helper.
package serial_mag_comp_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    // Bit-counter width for a WIDTH-pair comparison (never below one bit).
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/comp_1_bit_mag.sv
// Single-bit magnitude decision: flags which operand wins on this bit pair.
// Both outputs low means the bits are equal and the pair decides nothing.
module comp_1_bit_mag (
    input  logic i0,
    input  logic i1,
    output logic gt_b,
    output logic lt_b
);

    assign gt_b = i0 & ~i1;
    assign lt_b = ~i0 & i1;

endmodule

// File: rtl/serial_mag_comp.sv
// Bit-serial magnitude comparator. Operands A (i0) and B (i1) arrive MSB
// first, one pair per accepted cycle. The first unequal pair fixes gt/lt;
// the remaining pairs are still consumed so every comparison takes exactly
// WIDTH accepted pairs. eq is raised only if all pairs matched.
module serial_mag_comp
    import serial_mag_comp_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic i0,
    input  logic i1,
    input  logic in_valid,
    output logic in_ready,
    output logic busy,
    output logic done,
    output logic eq,
    output logic gt,
    output logic lt
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_decided;
    logic             r_eq;
    logic             r_gt;
    logic             r_lt;
    logic             w_gt_b;
    logic             w_lt_b;
    logic             w_accept;
    logic             w_last;
    logic             w_start;

    comp_1_bit_mag u_bit (
        .i0   (i0),
        .i1   (i1),
        .gt_b (w_gt_b),
        .lt_b (w_lt_b)
    );

    // Pair handshake and end-of-operand detection.
    assign w_start  = (r_state == IDLE) && start;
    assign w_accept = (r_state == SHIFT) && in_valid;
    assign w_last   = (r_cnt == LAST_IDX);

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and handshake/status outputs.
    // NOTE: every output gets a default first so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next_state = SHIFT;
            end
            SHIFT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && w_last) w_next_state = DONE;
            end
            DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Bit counter, decided flag and result flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_decided <= 1'b0;
            r_eq      <= 1'b0;
            r_gt      <= 1'b0;
            r_lt      <= 1'b0;
        end else if (w_start) begin
            r_cnt     <= '0;
            r_decided <= 1'b0;
            r_eq      <= 1'b0;
            r_gt      <= 1'b0;
            r_lt      <= 1'b0;
        end else if (w_accept) begin
            // Only the first unequal pair may set the ordering flags.
            if (!r_decided && (w_gt_b || w_lt_b)) begin
                r_gt      <= w_gt_b;
                r_lt      <= w_lt_b;
                r_decided <= 1'b1;
            end
            if (w_last) begin
                // Counter holds at the last index instead of wrapping.
                if (!r_decided && !(w_gt_b || w_lt_b)) r_eq <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign eq = r_eq;
    assign gt = r_gt;
    assign lt = r_lt;

endmodule

// File: tb/tb_serial_mag_comp.sv
// Self-checking bench for serial_mag_comp (WIDTH=8): directed vector table,
// hand-written reset/idle sequences and randomized comparisons checked
// against an integer-compare reference model.
module tb_serial_mag_comp;

    localparam int W      = 8;
    localparam int BUDGET = 200;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic i0;
    logic i1;
    logic in_valid;
    logic in_ready;
    logic busy;
    logic done;
    logic eq;
    logic gt;
    logic lt;

    int n_checks = 0;
    int n_errors = 0;

    serial_mag_comp #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .i0       (i0),
        .i1       (i1),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .eq       (eq),
        .gt       (gt),
        .lt       (lt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           stall_after;
        int           stall_len;
        bit           hold_start;
        logic [2:0]   exp_flags;   // {eq, gt, lt}
        int           exp_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: ordering of the k most significant bits of each operand.
    function automatic logic [2:0] prefix_flags(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input int k);
        int unsigned ap;
        int unsigned bp;
        if (k == 0) return 3'b000;
        ap = int'(a) >> (W - k);
        bp = int'(b) >> (W - k);
        return {1'b0, ap > bp, ap < bp};
    endfunction

    function automatic logic [2:0] final_flags(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a == b) return 3'b100;
        return (a > b) ? 3'b010 : 3'b001;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One comparison starting and ending at a negedge in IDLE. Returns the
    // cycle (relative to the start-sampling edge) at which done was seen.
    task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int stall_after, input int stall_len,
                           input bit hold_start, input bit rnd_stall,
                           input logic [2:0] exp_flags, input string tag,
                           output int lat, output int n_stall);
        int  k;
        int  cyc;
        int  stalls_here;
        bit  stall;
        k           = 0;
        cyc         = 1;
        stalls_here = 0;
        n_stall     = 0;
        start       = 1'b1;
        in_valid    = 1'b0;
        step();
        while (k < W && cyc < BUDGET) begin
            check({tag, " shift busy/ready"}, {30'd0, busy, in_ready}, 32'd3);
            check({tag, " partial flags"}, {29'd0, eq, gt, lt}, {29'd0, prefix_flags(a, b, k)});
            stall = (k == stall_after && stalls_here < stall_len) ||
                    (rnd_stall && $urandom_range(0, 3) == 0);
            start = hold_start;
            if (stall) begin
                if (k == stall_after && stalls_here < stall_len) stalls_here++;
                n_stall++;
                in_valid = 1'b0;
                i0       = 1'($urandom);
                i1       = 1'($urandom);
            end else begin
                in_valid = 1'b1;
                i0       = a[W-1-k];
                i1       = b[W-1-k];
                k++;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        while (!done && cyc < BUDGET) begin
            step();
            cyc++;
        end
        if (!done) check({tag, " done timeout"}, 32'd0, 32'd1);
        lat = cyc;
        check({tag, " result flags"}, {29'd0, eq, gt, lt}, {29'd0, exp_flags});
        step();
        check({tag, " done one cycle"}, {30'd0, done, busy}, 32'd0);
        check({tag, " flags held"}, {29'd0, eq, gt, lt}, {29'd0, exp_flags});
    endtask

    initial begin
        int lat;
        int ns;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        vecs[0] = '{8'hA5, 8'hA5, -1, 0, 1'b0, 3'b100, 9};
        vecs[1] = '{8'h80, 8'h7F, -1, 0, 1'b0, 3'b010, 9};
        vecs[2] = '{8'h3C, 8'h3D, -1, 0, 1'b0, 3'b001, 9};
        vecs[3] = '{8'h3C, 8'h3D,  4, 3, 1'b0, 3'b001, 12};
        vecs[4] = '{8'h00, 8'hFF, -1, 0, 1'b0, 3'b001, 9};
        vecs[5] = '{8'hFF, 8'hFF, -1, 0, 1'b0, 3'b100, 9};
        vecs[6] = '{8'h6E, 8'h12,  0, 2, 1'b1, 3'b010, 11};
        vecs[7] = '{8'hC3, 8'hC2,  7, 1, 1'b0, 3'b010, 10};

        rst      = 1'b1;
        start    = 1'b0;
        i0       = 1'b0;
        i1       = 1'b0;
        in_valid = 1'b0;
        #2;
        check("reset outputs", {26'd0, busy, in_ready, done, eq, gt, lt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("idle after reset", {26'd0, busy, in_ready, done, eq, gt, lt}, 32'd0);

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            run_cmp(vecs[i].a, vecs[i].b, vecs[i].stall_after, vecs[i].stall_len,
                    vecs[i].hold_start, 1'b0, vecs[i].exp_flags, $sformatf("vec%0d", i), lat, ns);
            check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
        end

        // in_valid ignored in IDLE: last vector left gt=1
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            i0       = 1'b0;
            i1       = 1'b1;
            step();
            check("idle ignores pairs", {26'd0, busy, in_ready, done, eq, gt, lt}, 32'b010);
        end
        in_valid = 1'b0;

        // Reset in the middle of a comparison, after pair 4 (A=0x80, B=0x7F)
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            i0       = ((8'h80 >> (W - 1 - k)) & 1) != 0;
            i1       = ((8'h7F >> (W - 1 - k)) & 1) != 0;
            step();
        end
        in_valid = 1'b0;
        check("pre-reset flags", {26'd0, busy, in_ready, done, eq, gt, lt}, 32'b110010);
        #2 rst = 1'b1;
        #1 check("async reset outputs", {26'd0, busy, in_ready, done, eq, gt, lt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            i0       = 1'b1;
            i1       = 1'b0;
            step();
            check("no done after abort", {26'd0, busy, in_ready, done, eq, gt, lt}, 32'd0);
        end
        in_valid = 1'b0;
        run_cmp(8'h01, 8'h00, -1, 0, 1'b0, 1'b0, 3'b010, "post-reset", lat, ns);
        check("post-reset latency", lat, 9);

        // Randomized comparisons with random stalls
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = (i % 5 == 0) ? ra : W'($urandom);
            if (i % 7 == 1) rb = ra ^ W'(1);
            run_cmp(ra, rb, -1, 0, 1'($urandom), 1'b1, final_flags(ra, rb),
                    $sformatf("rnd%0d", i), lat, ns);
            check($sformatf("rnd%0d latency", i), lat, W + 1 + ns);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_mag_comp.md
SERIAL_MAG_COMP -- requirements
Module: serial_mag_comp

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, number of bit pairs per comparison (legal range 2..64).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: start  input  1  request for a new comparison; sampled only in IDLE.
REQ-005 SHALL have port: i0  input  1  operand A bit, MSB first.
REQ-006 SHALL have port: i1  input  1  operand B bit, MSB first.
REQ-007 SHALL have port: in_valid  input  1  i0/i1 pair valid this cycle.
REQ-008 SHALL have port: in_ready  output  1  block accepts a pair this cycle.
REQ-009 SHALL have port: busy  output  1  comparison in progress (SHIFT or DONE).
REQ-010 SHALL have port: done  output  1  one-cycle pulse: result valid.
REQ-011 SHALL have ports: eq, gt, lt  output  1 each  registered result flags (A==B, A>B, A<B).

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-013 IDLE: start=1 SHALL clear eq/gt/lt, the bit counter and the decided flag, then go to SHIFT next cycle.
REQ-014 SHIFT: in_ready SHALL be 1; it SHALL be 0 in IDLE and DONE.
REQ-015 A pair SHALL be accepted only on cycles where in_valid & in_ready; each acceptance increments the counter.
REQ-016 On the first accepted pair with i0!=i1, gt<=i0&~i1 and lt<=~i0&i1; decided<=1.
REQ-017 Once decided, later pairs SHALL still be consumed and counted, but SHALL NOT change gt/lt.
REQ-018 Acceptance of pair WIDTH (counter==WIDTH-1) SHALL move to DONE; if still undecided, eq<=1 at that edge.
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-020 Latency: done SHALL assert the cycle after the last accepted pair; with no stalls, start at cycle T gives done at T+WIDTH+1.
REQ-021 After done, exactly one of eq/gt/lt SHALL be 1, held until the next accepted start.
REQ-022 start SHALL be ignored in SHIFT and DONE; in_valid SHALL be ignored outside SHIFT.
REQ-023 in_valid=0 in SHIFT SHALL stall: no state, counter or flag change.
REQ-024 Counter width SHALL be clog2(WIDTH), with no wrap-around inside one comparison.

Reset
REQ-025 rst=1 SHALL force, asynchronously: state IDLE, counter 0, decided 0, eq=gt=lt=0, done=0, busy=0, in_ready=0.
REQ-026 rst asserted mid-SHIFT SHALL abort the comparison with no done pulse; the next start after release SHALL operate normally.

Structure
REQ-027 State encoding (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10) and the WIDTH default SHALL live in the shared comparator package.
REQ-028 The per-bit gt/lt decision SHALL be one combinational sub-module, comp_1_bit_mag (in i0,i1; out gt_b,lt_b); the FSM, counter and flags live in serial_mag_comp.

Verification (WIDTH=8)
REQ-029 A=0xA5, B=0xA5, no stalls -> done at T+9; eq=1, gt=0, lt=0.
REQ-030 A=0x80, B=0x7F -> decided on pair 1, but done still at T+9; gt=1, eq=lt=0.
REQ-031 A=0x3C, B=0x3D -> lt=1 decided on pair 8; done at T+9.
REQ-032 A=0x3C, B=0x3D, in_valid=0 for 3 cycles after pair 4 -> done at T+12; lt=1; flags unchanged during the stall.
REQ-033 rst pulse after pair 4 -> all outputs 0 immediately, no done; a new start with A=0x01, B=0x00 -> gt=1 at T'+9.
REQ-034 start asserted again during SHIFT -> ignored; the original comparison completes with its correct result.
